// File: rtl/tpu_output_postproc.sv
// tpu_output_postproc
//   Post-processes systolic-array result rows and streams them to the CPU/DMA.
//   Per row: per-column bias add (saturating), rounding arithmetic right shift,
//   optional ReLU, saturation to 16 bits, then queued in a row FIFO and emitted
//   as 32-bit words carrying two 16-bit lanes each.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   array_outputs/_valid result row from the array (no backpressure)
//   in_ready            advisory: a row arriving now will not be dropped
//   cfg_*               shift, ReLU enable, bias write port, datapath clear
//   out_data/valid/ready/last  32-bit word stream, last marks end of row
//   rows_done           rows fully drained (wraps)
//   overflow_err        sticky: a row was dropped
//   sat_err             sticky: a lane saturated to 16 bits
module tpu_output_postproc #(
  parameter int unsigned ARRAY_SIZE     = 8,
  parameter int unsigned ACC_BITS       = 32,
  parameter int unsigned ROW_FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ARRAY_SIZE*ACC_BITS-1:0]   array_outputs,
  input  logic                             array_output_valid,
  output logic                             in_ready,
  input  logic [4:0]                       cfg_shift,
  input  logic                             cfg_relu_en,
  input  logic                             cfg_bias_wr,
  input  logic [$clog2(ARRAY_SIZE)-1:0]    cfg_bias_col,
  input  logic [ACC_BITS-1:0]              cfg_bias_data,
  input  logic                             cfg_clear,
  output logic [31:0]                      out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic [15:0]                      rows_done,
  output logic                             overflow_err,
  output logic                             sat_err
);

  localparam int unsigned NumWords = ARRAY_SIZE / 2;
  localparam int unsigned KW       = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned PW       = (ROW_FIFO_DEPTH > 1) ? $clog2(ROW_FIFO_DEPTH) : 1;
  localparam int unsigned CW       = $clog2(ROW_FIFO_DEPTH + 1);
  localparam int unsigned RowW     = ARRAY_SIZE * 16;
  localparam logic signed [ACC_BITS:0] Max16 = (ACC_BITS + 1)'(32767);
  localparam logic signed [ACC_BITS:0] Min16 = (ACC_BITS + 1)'(-32768);

  // Saturating ACC_BITS-wide add, computed one bit wider so it never wraps.
  function automatic logic [ACC_BITS-1:0] add_sat(input logic [ACC_BITS-1:0] a,
                                                 input logic [ACC_BITS-1:0] b);
    logic [ACC_BITS:0] w;
    w = {a[ACC_BITS-1], a} + {b[ACC_BITS-1], b};
    if (w[ACC_BITS] != w[ACC_BITS-1]) begin
      return w[ACC_BITS] ? {1'b1, {(ACC_BITS-1){1'b0}}} : {1'b0, {(ACC_BITS-1){1'b1}}};
    end
    return w[ACC_BITS-1:0];
  endfunction

  // Round-shift, ReLU, clip to 16 bits. Returns {clipped, lane[15:0]}.
  function automatic logic [16:0] post(input logic [ACC_BITS-1:0] x, input logic [4:0] s,
                                       input logic relu);
    logic signed [ACC_BITS:0] w;
    logic signed [ACC_BITS:0] rnd;
    w   = {x[ACC_BITS-1], x};
    rnd = '0;
    if (s != 5'd0) rnd = (ACC_BITS + 1)'(1) << (s - 5'd1);
    w = (w + rnd) >>> s;
    if (relu && w < 0) w = '0;
    if (w > Max16) return {1'b1, 16'h7fff};
    if (w < Min16) return {1'b1, 16'h8000};
    return {1'b0, w[15:0]};
  endfunction

  logic [ACC_BITS-1:0] bias_q   [ARRAY_SIZE];
  logic [ACC_BITS-1:0] s1_sum_q [ARRAY_SIZE];
  logic [ACC_BITS-1:0] s1_sum_d [ARRAY_SIZE];
  logic                s1_valid_q, s2_valid_q;
  logic [RowW-1:0]     s2_row_q, s2_row_d;
  logic                s2_clip_d;
  logic [16:0]         s2_res   [ARRAY_SIZE];
  logic [RowW-1:0]     mem_q    [ROW_FIFO_DEPTH];
  logic [PW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]       count_q;
  logic [KW-1:0]       k_q;
  logic [15:0]         rows_done_q;
  logic                overflow_q, sat_q;
  logic [RowW-1:0]     head;
  logic                full, hs, pop, push, drop;
  logic [CW:0]         occ;

  always_comb begin
    s2_row_d  = '0;
    s2_clip_d = 1'b0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      s1_sum_d[i] = add_sat(array_outputs[i*ACC_BITS +: ACC_BITS], bias_q[i]);
      s2_res[i]   = post(s1_sum_q[i], cfg_shift, cfg_relu_en);
      s2_row_d[i*16 +: 16] = s2_res[i][15:0];
      s2_clip_d = s2_clip_d | s2_res[i][16];
    end
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_valid = (count_q != '0);
    out_data  = out_valid ? head[{k_q, 5'd0} +: 32] : 32'd0;
    out_last  = out_valid && (k_q == KW'(NumWords - 1));
    hs        = out_valid && out_ready;
    pop       = hs && out_last;
    full      = (count_q == CW'(ROW_FIFO_DEPTH));
    // When full, a same-cycle pop frees exactly the slot the push writes.
    push      = s2_valid_q && (!full || pop);
    drop      = s2_valid_q && full && !pop;
    occ       = {1'b0, count_q} + (CW + 1)'(s1_valid_q) + (CW + 1)'(s2_valid_q);
    in_ready  = (occ < (CW + 1)'(ROW_FIFO_DEPTH));
  end

  assign rows_done    = rows_done_q;
  assign overflow_err = overflow_q;
  assign sat_err      = sat_q;

  // Data registers; qualified by the valid/control state below, so no reset needed.
  always_ff @(posedge clk) begin
    s1_sum_q <= s1_sum_d;
    s2_row_q <= s2_row_d;
    if (!rst && !cfg_clear && push) mem_q[wr_ptr_q] <= s2_row_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARRAY_SIZE; i++) bias_q[i] <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      k_q         <= '0;
      rows_done_q <= '0;
      overflow_q  <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      if (cfg_bias_wr) bias_q[cfg_bias_col] <= cfg_bias_data;
      if (cfg_clear) begin
        s1_valid_q  <= 1'b0;
        s2_valid_q  <= 1'b0;
        rd_ptr_q    <= '0;
        wr_ptr_q    <= '0;
        count_q     <= '0;
        k_q         <= '0;
        rows_done_q <= '0;
        overflow_q  <= 1'b0;
        sat_q       <= 1'b0;
      end else begin
        s1_valid_q <= array_output_valid;
        s2_valid_q <= s1_valid_q;
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop) begin
          rd_ptr_q    <= rd_ptr_q + PW'(1);
          rows_done_q <= rows_done_q + 16'd1;
        end
        unique case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
        if (hs) k_q <= pop ? '0 : k_q + KW'(1);
        if (drop) overflow_q <= 1'b1;
        if (s1_valid_q && s2_clip_d) sat_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tpu_output_postproc.sv
module tb_tpu_output_postproc;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] array_outputs;
  logic         array_output_valid;
  logic         in_ready;
  logic [4:0]   cfg_shift;
  logic         cfg_relu_en;
  logic         cfg_bias_wr;
  logic [2:0]   cfg_bias_col;
  logic [31:0]  cfg_bias_data;
  logic         cfg_clear;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [15:0]  rows_done;
  logic         overflow_err;
  logic         sat_err;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] lanes [8];
  logic        saw_low;

  always #5 clk = ~clk;

  tpu_output_postproc #(
    .ARRAY_SIZE    (8),
    .ACC_BITS      (32),
    .ROW_FIFO_DEPTH(4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .array_outputs     (array_outputs),
    .array_output_valid(array_output_valid),
    .in_ready          (in_ready),
    .cfg_shift         (cfg_shift),
    .cfg_relu_en       (cfg_relu_en),
    .cfg_bias_wr       (cfg_bias_wr),
    .cfg_bias_col      (cfg_bias_col),
    .cfg_bias_data     (cfg_bias_data),
    .cfg_clear         (cfg_clear),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .rows_done         (rows_done),
    .overflow_err      (overflow_err),
    .sat_err           (sat_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes;
    for (int i = 0; i < 8; i++) lanes[i] = '0;
  endtask

  task automatic load_row;
    for (int i = 0; i < 8; i++) array_outputs[i*32 +: 32] = lanes[i];
  endtask

  task automatic apply_row;
    load_row();
    array_output_valid = 1'b1;
    tick();
    array_output_valid = 1'b0;
  endtask

  task automatic bias_wr(input logic [2:0] col, input logic [31:0] data);
    cfg_bias_wr   = 1'b1;
    cfg_bias_col  = col;
    cfg_bias_data = data;
    tick();
    cfg_bias_wr = 1'b0;
  endtask

  task automatic pulse_clear;
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, " valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic drain4(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    out_ready = 1'b1;
    wait_valid(tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, " data"}, out_data, w[i]);
      check({tag, " last"}, {31'd0, out_last}, (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; array_outputs = '0; array_output_valid = 1'b0;
    cfg_shift = '0; cfg_relu_en = 1'b0; cfg_bias_wr = 1'b0; cfg_bias_col = '0;
    cfg_bias_data = '0; cfg_clear = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_data", out_data, 32'd0);
    check("rst rows_done", {16'd0, rows_done}, 32'd0);
    check("rst ovf", {31'd0, overflow_err}, 32'd0);
    check("rst sat", {31'd0, sat_err}, 32'd0);

    // 1: plain pass-through
    lanes[0] = 32'd1; lanes[1] = -32'sd2; lanes[2] = 32'd3; lanes[3] = -32'sd4;
    lanes[4] = 32'd5; lanes[5] = -32'sd6; lanes[6] = 32'd7; lanes[7] = -32'sd8;
    apply_row();
    drain4("t1", 32'hFFFE0001, 32'hFFFC0003, 32'hFFFA0005, 32'hFFF80007);
    check("t1 rows_done", {16'd0, rows_done}, 32'd1);

    // 2: bias, rounding shift, ReLU
    bias_wr(3'd3, 32'd100);
    cfg_shift = 5'd4; cfg_relu_en = 1'b1;
    clear_lanes(); lanes[3] = 32'd1000; lanes[0] = -32'sd50;
    apply_row();
    drain4("t2", 32'h0, 32'h00450000, 32'h0, 32'h0);
    check("t2 sat", {31'd0, sat_err}, 32'd0);

    // 3: old bias on same-cycle write, then double saturation
    cfg_shift = 5'd0; cfg_relu_en = 1'b0;
    clear_lanes(); lanes[0] = 32'd5;
    cfg_bias_wr = 1'b1; cfg_bias_col = 3'd0; cfg_bias_data = 32'h100;
    apply_row();
    cfg_bias_wr = 1'b0;
    drain4("t3a", 32'h5, 32'h00640000, 32'h0, 32'h0);
    check("t3a sat", {31'd0, sat_err}, 32'd0);
    lanes[0] = 32'h7FFFFFF0;
    apply_row();
    drain4("t3b", 32'h00007FFF, 32'h00640000, 32'h0, 32'h0);
    check("t3b sat", {31'd0, sat_err}, 32'd1);

    // 4: overflow with stalled consumer
    pulse_clear();
    check("t4 clr sat", {31'd0, sat_err}, 32'd0);
    check("t4 clr rows", {16'd0, rows_done}, 32'd0);
    bias_wr(3'd0, 32'd0);
    bias_wr(3'd3, 32'd0);
    out_ready = 1'b0;
    saw_low = 1'b0;
    for (int r = 1; r <= 6; r++) begin
      if (!in_ready) saw_low = 1'b1;
      clear_lanes(); lanes[0] = 32'(r);
      apply_row();
    end
    check("t4 in_ready fell", {31'd0, saw_low}, 32'd1);
    repeat (4) tick();
    check("t4 ovf", {31'd0, overflow_err}, 32'd1);
    check("t4 head stable", out_data, 32'd1);
    for (int r = 1; r <= 4; r++) drain4("t4", 32'(r), 32'h0, 32'h0, 32'h0);
    check("t4 drained", {31'd0, out_valid}, 32'd0);
    check("t4 rows_done", {16'd0, rows_done}, 32'd4);

    // 5: push into full FIFO on the pop cycle
    pulse_clear();
    out_ready = 1'b0;
    for (int r = 'h11; r <= 'h14; r++) begin
      clear_lanes(); lanes[0] = 32'(r);
      apply_row();
    end
    repeat (4) tick();
    check("t5 full in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    check("t5 w0", out_data, 32'h11);
    tick();
    clear_lanes(); lanes[0] = 32'h15;
    load_row();
    array_output_valid = 1'b1;
    check("t5 w1", out_data, 32'h0);
    tick();
    array_output_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    check("t5 ovf", {31'd0, overflow_err}, 32'd0);
    check("t5 rows", {16'd0, rows_done}, 32'd1);
    check("t5 next head", out_data, 32'h12);
    for (int r = 'h12; r <= 'h15; r++) drain4("t5", 32'(r), 32'h0, 32'h0, 32'h0);
    check("t5 rows_done", {16'd0, rows_done}, 32'd5);

    // 6: clear while stalled mid-row
    bias_wr(3'd1, 32'd7);
    out_ready = 1'b0;
    clear_lanes(); lanes[0] = 32'h21; lanes[2] = 32'h22;
    apply_row();
    wait_valid("t6");
    check("t6 w0", out_data, 32'h00070021);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t6 w1", out_data, 32'h22);
    tick();
    check("t6 w1 stable", out_data, 32'h22);
    pulse_clear();
    check("t6 clr valid", {31'd0, out_valid}, 32'd0);
    check("t6 clr rows", {16'd0, rows_done}, 32'd0);
    clear_lanes(); lanes[0] = 32'h31; lanes[2] = 32'h32;
    apply_row();
    drain4("t6b", 32'h00070031, 32'h32, 32'h0, 32'h0);
    check("t6 rows_done", {16'd0, rows_done}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
